// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the two-port memory arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  localparam logic [1:0] RW_IDLE  = 2'b00;
  localparam logic [1:0] RW_WRITE = 2'b01;
  localparam logic [1:0] RW_READ  = 2'b10;

endpackage

// File: rtl/mem_arbiter_if.sv
// Requester ports, memory-side bus and busy flag of the two-port memory arbiter.
interface mem_arbiter_if #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 16
);
  logic              p0_req, p1_req;
  logic              p0_we, p1_we;
  logic [ADDR_W-1:0] p0_addr, p1_addr;
  logic [DATA_W-1:0] p0_wdata, p1_wdata;
  logic              p0_ack, p1_ack;
  logic [DATA_W-1:0] p0_rdata, p1_rdata;
  logic [1:0]        mem_rw;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_data_in;
  logic [DATA_W-1:0] mem_data_outs;
  logic              busy;

  // Arbiter side.
  modport slave (
    input  p0_req, p1_req, p0_we, p1_we, p0_addr, p1_addr, p0_wdata, p1_wdata,
    input  mem_data_outs,
    output p0_ack, p1_ack, p0_rdata, p1_rdata, mem_rw, mem_addr, mem_data_in, busy
  );

  // Requesters plus memory side.
  modport master (
    output p0_req, p1_req, p0_we, p1_we, p0_addr, p1_addr, p0_wdata, p1_wdata,
    output mem_data_outs,
    input  p0_ack, p1_ack, p0_rdata, p1_rdata, mem_rw, mem_addr, mem_data_in, busy
  );
endinterface

// File: rtl/rr_arb2.sv
// Two-way round-robin grant: prio selects which port wins a tie.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       prio,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = 2'b00;
    if (req == 2'b11)  gnt = prio ? 2'b10 : 2'b01;
    else if (req[0])   gnt = 2'b01;
    else if (req[1])   gnt = 2'b10;
  end

endmodule

// File: rtl/mem_arbiter.sv
// Two-port round-robin arbiter in front of a single-port synchronous memory.
// Each transaction runs IDLE -> ACCESS -> DONE; all outputs are registered.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 16
) (
  input logic          clk,
  input logic          rst_n,
  mem_arbiter_if.slave bus
);

  state_t            state_q, state_d;
  logic [1:0]        req, gnt;
  logic              prio_q;     // 1: port 1 wins a tie
  logic              winner_q;   // 1: port 1 owns the current transaction
  logic [1:0]        mem_rw_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_data_in_q;
  logic [DATA_W-1:0] p0_rdata_q, p1_rdata_q;
  logic              p0_ack_q, p1_ack_q, busy_q;

  assign req = {bus.p1_req, bus.p0_req};

  rr_arb2 u_rr_arb2 (
    .req  (req),
    .prio (prio_q),
    .gnt  (gnt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: non-blocking (<=) in clocked blocks so every register sees pre-edge values.
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    // NOTE: default assigned first so no branch leaves state_d unassigned (no latch).
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (|req) state_d = ACCESS;
      ACCESS:  state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prio_q        <= 1'b0;
      winner_q      <= 1'b0;
      mem_rw_q      <= RW_IDLE;
      mem_addr_q    <= '0;
      mem_data_in_q <= '0;
      p0_rdata_q    <= '0;
      p1_rdata_q    <= '0;
      p0_ack_q      <= 1'b0;
      p1_ack_q      <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      p0_ack_q <= 1'b0;
      p1_ack_q <= 1'b0;
      case (state_q)
        IDLE: if (|req) begin
          winner_q      <= gnt[1];
          prio_q        <= gnt[0];   // the port just served loses the next tie
          mem_rw_q      <= (gnt[1] ? bus.p1_we : bus.p0_we) ? RW_WRITE : RW_READ;
          mem_addr_q    <= gnt[1] ? bus.p1_addr  : bus.p0_addr;
          mem_data_in_q <= gnt[1] ? bus.p1_wdata : bus.p0_wdata;
          busy_q        <= 1'b1;
        end
        ACCESS: begin
          mem_rw_q <= RW_IDLE;
          if (mem_rw_q == RW_READ) begin
            if (winner_q) p1_rdata_q <= bus.mem_data_outs;
            else          p0_rdata_q <= bus.mem_data_outs;
          end
          p0_ack_q <= !winner_q;
          p1_ack_q <= winner_q;
        end
        DONE:    busy_q <= 1'b0;
        default: busy_q <= 1'b0;
      endcase
    end
  end

  assign bus.mem_rw      = mem_rw_q;
  assign bus.mem_addr    = mem_addr_q;
  assign bus.mem_data_in = mem_data_in_q;
  assign bus.p0_rdata    = p0_rdata_q;
  assign bus.p1_rdata    = p1_rdata_q;
  assign bus.p0_ack      = p0_ack_q;
  assign bus.p1_ack      = p1_ack_q;
  assign bus.busy        = busy_q;

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 5, memory word-address width (32 words).
REQ-002 SHALL have parameter DATA_W, default 16, memory word width.
REQ-003 SHALL use one clock; reset is asynchronous and active-low.
REQ-004 Port: clk  input  1  rising-edge clock shared with the memory.
REQ-005 Port: rst_n  input  1  asynchronous active-low reset.
REQ-006 Port: p0_req / p1_req  input  1  request from port 0 (fetch) / port 1 (data); held until ack.
REQ-007 Port: p0_we / p1_we  input  1  1 = write, 0 = read; held with req.
REQ-008 Port: p0_addr / p1_addr  input  ADDR_W  word address; held with req.
REQ-009 Port: p0_wdata / p1_wdata  input  DATA_W  write data; held with req.
REQ-010 Port: p0_ack / p1_ack  output  1  one-cycle completion pulse.
REQ-011 Port: p0_rdata / p1_rdata  output  DATA_W  read data, valid while ack=1, held until that port's next ack.
REQ-012 Port: mem_rw  output  2  to memory rw: 00 idle, 01 write, 10 read; 11 never driven.
REQ-013 Port: mem_addr  output  ADDR_W  to memory addr.
REQ-014 Port: mem_data_in  output  DATA_W  to memory data_in.
REQ-015 Port: mem_data_outs  input  DATA_W  from memory; combinational, valid while mem_rw=10.
REQ-016 Port: busy  output  1  high in ACCESS and DONE.

Function
REQ-017 SHALL implement FSM IDLE -> ACCESS -> DONE -> IDLE, unconditional after IDLE.
REQ-018 In IDLE with any req high, SHALL select a winner and on that edge register mem_rw/mem_addr/mem_data_in from it, entering ACCESS.
REQ-019 In ACCESS, mem_rw SHALL be 01 (we=1) or 10 (we=0); memory writes on the edge ending ACCESS.
REQ-020 On the edge ending ACCESS, for a read, SHALL capture mem_data_outs into the winner's rdata register.
REQ-021 In DONE, SHALL assert the winner's ack for exactly one cycle, mem_rw=00; the other port's ack SHALL stay 0.
REQ-022 Latency: req sampled in IDLE at edge N -> ack high in cycle after edge N+1; one transaction per 3 cycles max.
REQ-023 Arbitration SHALL be 2-way round-robin: on simultaneous req, grant the port not granted last; a lone requester wins.
REQ-024 Priority pointer SHALL update only on grant; after reset port 0 has priority.
REQ-025 Requester SHALL drop req in the cycle after ack or re-request; a req still high in IDLE after DONE is a new transaction.
REQ-026 Request inputs SHALL be sampled only in IDLE; changes during ACCESS/DONE are ignored.
REQ-027 mem_rw SHALL be 00 in IDLE and DONE; mem_addr/mem_data_in hold their last values outside ACCESS.
REQ-028 Back-to-back writes then read to the same address SHALL return the written data (no bypass needed; ordering is serial).

Reset
REQ-029 rst_n low SHALL immediately force: state IDLE, mem_rw=00, mem_addr=0, mem_data_in=0, p0/p1_ack=0, p0/p1_rdata=0, busy=0, priority to port 0.
REQ-030 Reset asserted during ACCESS SHALL abort the transaction: no ack issued; a write may or may not have landed.
REQ-031 First grant SHALL occur no earlier than the first rising edge after rst_n deasserts.

Structure
REQ-032 Package mem_arb_pkg SHALL hold state enum (IDLE, ACCESS, DONE) and rw constants RW_IDLE=2'b00, RW_WRITE=2'b01, RW_READ=2'b10.
REQ-033 SHALL instantiate one sub-module rr_arb2: inputs req[1:0], prio; output one-hot gnt[1:0]; combinational.
REQ-034 All outputs SHALL be registered; no combinational path from req to mem_*.

Verification
REQ-035 Reset then p1 write addr 5 data 16'hBEEF -> mem_rw=01, mem_addr=5 for one cycle, p1_ack pulse 2 cycles after grant edge.
REQ-036 p0 read addr 5 after REQ-035 -> mem_rw=10, p0_rdata=16'hBEEF while p0_ack=1; p1_ack stays 0.
REQ-037 p0 and p1 req same edge after reset, held -> grant order p0, p1, p0, p1; acks 3 cycles apart.
REQ-038 rst_n pulsed low mid-ACCESS of a read -> mem_rw=00 and busy=0 asynchronously, no ack, next grant goes to p0.
REQ-039 p0 changes addr 3->7 during ACCESS -> access completes to addr 3; mem_rw never 11 in any scenario.
